// File: rtl/debug_mode_ctrl.sv
// Per-hart debug-mode controller: decides debug entry, captures dpc/cause, issues fetch redirects.
// Optional single-step support (STEP state, cause 4) is enabled by defining DM_SINGLE_STEP_EN.
module debug_mode_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] HaltAddr = XLEN'('h800),
  parameter logic [XLEN-1:0] ExcAddr  = XLEN'('h808)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            debug_req_i,
  input  logic            step_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] commit_npc_i,
  input  logic            ebreak_i,
  input  logic            trigger_i,
  input  logic            dret_i,
  input  logic            exc_i,
  input  logic            dpc_we_i,
  input  logic [XLEN-1:0] dpc_wdata_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            debug_mode_o,
  output logic [XLEN-1:0] dpc_o,
  output logic [2:0]      cause_o
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DEBUG = 2'd2;
`ifdef DM_SINGLE_STEP_EN
  localparam logic [1:0] STEP  = 2'd1;
`else
  logic unused_step;
  assign unused_step = step_i;
`endif

  logic [1:0]      state, state_n;
  logic            redir_n;
  logic [XLEN-1:0] rpc_n, dpc_n;
  logic [2:0]      cause_n;

  always_comb begin
    state_n = state;
    redir_n = 1'b0;
    rpc_n   = redirect_pc_o;
    dpc_n   = dpc_o;
    cause_n = cause_o;
    // The redirect cycle is a flush: every request is dropped.
    if (!redirect_o) begin
      if (state == DEBUG) begin
        if (exc_i) begin
          redir_n = 1'b1;
          rpc_n   = ExcAddr;
        end else if (commit_valid_i && ebreak_i) begin
          redir_n = 1'b1;
          rpc_n   = HaltAddr;
        end else if (commit_valid_i && dret_i) begin
          redir_n = 1'b1;
          rpc_n   = dpc_o;
`ifdef DM_SINGLE_STEP_EN
          state_n = step_i ? STEP : RUN;
`else
          state_n = RUN;
`endif
        end
        // Redirect above already latched the pre-write dpc.
        if (commit_valid_i && dpc_we_i) dpc_n = dpc_wdata_i;
      end else if (commit_valid_i) begin
        if (trigger_i) begin
          redir_n = 1'b1;
          dpc_n   = commit_pc_i;
          cause_n = 3'd2;
        end else if (ebreak_i) begin
          redir_n = 1'b1;
          dpc_n   = commit_pc_i;
          cause_n = 3'd1;
        end else if (debug_req_i) begin
          redir_n = 1'b1;
          dpc_n   = commit_npc_i;
          cause_n = 3'd3;
        end
`ifdef DM_SINGLE_STEP_EN
        else if (state == STEP) begin
          redir_n = 1'b1;
          dpc_n   = commit_npc_i;
          cause_n = 3'd4;
        end
`endif
        if (redir_n) begin
          state_n = DEBUG;
          rpc_n   = HaltAddr;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      debug_mode_o  <= 1'b0;
      dpc_o         <= '0;
      cause_o       <= 3'd0;
    end else begin
      state         <= state_n;
      redirect_o    <= redir_n;
      redirect_pc_o <= rpc_n;
      debug_mode_o  <= (state_n == DEBUG);
      dpc_o         <= dpc_n;
      cause_o       <= cause_n;
    end
  end

endmodule
